// File: rtl/req_arb_pkg.sv
// Shared widths, FSM encoding, offer payload and round-robin pick for req_arbiter4.
package req_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Offer payload towards the encoder stage: one-hot grant plus its index.
  typedef struct packed {
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] code;
  } offer_t;

  // First set bit of pending, searching ptr, ptr+1, ... modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] pending,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && pending[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/req_arbiter4_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line plus rising-edge detect.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;

  // Shift the raw level through the synchroniser, then keep one delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], req};
      sync_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~sync_d_q;

endmodule

// File: rtl/req_arbiter4.sv
// Four-line request capture with sticky pending events and a round-robin
// valid/ready offer of one event at a time.
module req_arbiter4
  import req_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DROP_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_i,
  output logic [N_REQ-1:0]  grant_o,
  output logic [IDX_W-1:0]  code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_REQ-1:0]  pending_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  // Wide enough to hold the counter plus up to N_REQ drops in one cycle.
  localparam int unsigned      CNT_W    = DROP_W + 3;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [N_REQ-1:0]  rise_c;
  state_t            state_q;
  logic [IDX_W-1:0]  ptr_q;
  offer_t            offer_q;
  logic              valid_q;
  logic [N_REQ-1:0]  pending_q;
  logic [DROP_W-1:0] drop_q;

  logic              fire_c;
  logic              clr_c;
  logic [N_REQ-1:0]  pending_nxt_c;
  logic [N_REQ-1:0]  drop_vec_c;
  logic [CNT_W-1:0]  drop_sum_c;
  logic [DROP_W-1:0] drop_nxt_c;
  logic [IDX_W-1:0]  pick_c;

  // One synchroniser and edge detector per request line.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_line
    sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_i[gi]),
      .rise_c(rise_c[gi])
    );
  end

  // Pending set/clear (set wins), dropped-event detection and saturating count.
  always_comb begin
    fire_c        = valid_q & ready_i;
    clr_c         = 1'b0;
    pending_nxt_c = pending_q;
    drop_vec_c    = '0;
    drop_sum_c    = CNT_W'(drop_q);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      clr_c = fire_c && (offer_q.code == IDX_W'(i));
      if (rise_c[i]) begin
        pending_nxt_c[i] = 1'b1;
        drop_vec_c[i]    = pending_q[i] & ~clr_c;
      end else if (clr_c) begin
        pending_nxt_c[i] = 1'b0;
      end
      drop_sum_c = drop_sum_c + CNT_W'(drop_vec_c[i]);
    end
    drop_nxt_c = (drop_sum_c > CNT_W'(DROP_MAX)) ? DROP_MAX : DROP_W'(drop_sum_c);
    pick_c     = rr_pick(pending_q, ptr_q);
  end

  // Pending register and dropped-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_nxt_c;
      drop_q    <= drop_nxt_c;
    end
  end

  // Offer FSM: pick from last cycle's pending in IDLE, hold the offer until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      offer_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            offer_q.grant <= N_REQ'(1) << pick_c;
            offer_q.code  <= pick_c;
            valid_q       <= 1'b1;
            state_q       <= OFFER;
          end
        end
        OFFER: begin
          if (ready_i) begin
            ptr_q   <= offer_q.code + IDX_W'(1);
            offer_q <= '0;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          offer_q <= '0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_o    = offer_q.grant;
  assign code_o     = offer_q.code;
  assign valid_o    = valid_q;
  assign pending_o  = pending_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// Bench for req_arbiter4: cycle table plus hand sequences for saturation and async reset.
module tb_req_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic       ready_i;
  logic [3:0] grant_o;
  logic [1:0] code_o;
  logic       valid_o;
  logic [3:0] pending_o;
  logic [3:0] drop_cnt_o;

  req_arbiter4 #(
    .SYNC_STAGES(2),
    .DROP_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .grant_o   (grant_o),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pending_o (pending_o),
    .drop_cnt_o(drop_cnt_o)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    int         push;
    logic       v;
    logic [3:0] g;
    logic [1:0] c;
    logic [3:0] p;
    logic [3:0] d;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic v, input logic [3:0] g,
                           input logic [1:0] c, input logic [3:0] p, input logic [3:0] d);
    check({nm, ".valid"},   32'(valid_o),    32'(v));
    check({nm, ".grant"},   32'(grant_o),    32'(g));
    check({nm, ".code"},    32'(code_o),     32'(c));
    check({nm, ".pending"}, 32'(pending_o),  32'(p));
    check({nm, ".drop"},    32'(drop_cnt_o), 32'(d));
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic rd, input int push,
                     input logic v, input logic [3:0] g, input logic [1:0] c,
                     input logic [3:0] p, input logic [3:0] d);
    vec_t x;
    x.rst_n = r; x.req = rq; x.rdy = rd; x.push = push;
    x.v = v; x.g = g; x.c = c; x.p = p; x.d = d;
    vecs.push_back(x);
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic rd);
    rst_n   = r;
    req_i   = rq;
    ready_i = rd;
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every accepted offer must match the next expected line.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      logic [1:0] e;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: handshake on code %0d, none queued", code_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_code",  32'(code_o),  32'(e));
        check("sb_grant", 32'(grant_o), 32'(4'b0001 << e));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    req_i   = 4'b0000;
    ready_i = 1'b0;

    // Single event on line 2: offer three edges after the first sampling edge.
    add(1'b1, 4'b0100, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0100, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0100, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0100, 4'd0);
    add(1'b1, 4'b0100, 1'b0,  2, 1'b1, 4'b0100, 2'd2, 4'b0100, 4'd0);
    add(1'b1, 4'b0100, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0000, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    // All four together with a zero-wait consumer, then ptr wrap check.
    add(1'b0, 4'b0000, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b0, 4'b0000, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b1111, 4'd0);
    add(1'b1, 4'b1111, 1'b1,  0, 1'b1, 4'b0001, 2'd0, 4'b1111, 4'd0);
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b1110, 4'd0);
    add(1'b1, 4'b1111, 1'b1,  1, 1'b1, 4'b0010, 2'd1, 4'b1110, 4'd0);
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b1100, 4'd0);
    add(1'b1, 4'b1111, 1'b1,  2, 1'b1, 4'b0100, 2'd2, 4'b1100, 4'd0);
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b1000, 4'd0);
    add(1'b1, 4'b1111, 1'b1,  3, 1'b1, 4'b1000, 2'd3, 4'b1000, 4'd0);
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0000, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0000, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b1001, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b1001, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b1001, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b1001, 4'd0);
    add(1'b1, 4'b1001, 1'b1,  0, 1'b1, 4'b0001, 2'd0, 4'b1001, 4'd0);
    add(1'b1, 4'b1001, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b1000, 4'd0);
    add(1'b1, 4'b1001, 1'b1,  3, 1'b1, 4'b1000, 2'd3, 4'b1000, 4'd0);
    add(1'b1, 4'b1001, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    // Line 1 held without ready for 10 cycles while three more edges are dropped.
    add(1'b0, 4'b0000, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b0, 4'b0000, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0010, 4'd0);
    add(1'b1, 4'b0010, 1'b0,  1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd0);
    add(1'b1, 4'b0000, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd0);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd0);
    add(1'b1, 4'b0000, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd0);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd1);
    add(1'b1, 4'b0000, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd1);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd2);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd2);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd3);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd3);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd3);
    add(1'b1, 4'b0010, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd3);
    // Line 3 re-rises in the cycle its own offer is accepted: kept pending, no drop.
    add(1'b1, 4'b1010, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd3);
    add(1'b1, 4'b1010, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd3);
    add(1'b1, 4'b1010, 1'b0, -1, 1'b0, 4'b0000, 2'd0, 4'b1000, 4'd3);
    add(1'b1, 4'b1010, 1'b0,  3, 1'b1, 4'b1000, 2'd3, 4'b1000, 4'd3);
    add(1'b1, 4'b0010, 1'b0, -1, 1'b1, 4'b1000, 2'd3, 4'b1000, 4'd3);
    add(1'b1, 4'b1010, 1'b0, -1, 1'b1, 4'b1000, 2'd3, 4'b1000, 4'd3);
    add(1'b1, 4'b1010, 1'b0, -1, 1'b1, 4'b1000, 2'd3, 4'b1000, 4'd3);
    add(1'b1, 4'b1010, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b1000, 4'd3);
    add(1'b1, 4'b1010, 1'b1,  3, 1'b1, 4'b1000, 2'd3, 4'b1000, 4'd3);
    add(1'b1, 4'b1010, 1'b1, -1, 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd3);

    repeat (2) @(posedge clk);
    #2;
    check_out("reset", 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n   = vecs[i].rst_n;
      req_i   = vecs[i].req;
      ready_i = vecs[i].rdy;
      if (vecs[i].push >= 0) exp_q.push_back(2'(vecs[i].push));
      @(posedge clk);
      #2;
      check_out($sformatf("row%0d", i), vecs[i].v, vecs[i].g, vecs[i].c, vecs[i].p, vecs[i].d);
    end

    // Saturation: all four lines pending, each pulse drops four events.
    step(1'b0, 4'b0000, 1'b0);
    repeat (4) step(1'b1, 4'b1111, 1'b0);
    check_out("sat_offer", 1'b1, 4'b0001, 2'd0, 4'b1111, 4'd0);
    repeat (2) begin
      step(1'b1, 4'b0000, 1'b0);
      step(1'b1, 4'b1111, 1'b0);
    end
    repeat (2) step(1'b1, 4'b1111, 1'b0);
    check_out("sat_mid", 1'b1, 4'b0001, 2'd0, 4'b1111, 4'd8);
    repeat (3) begin
      step(1'b1, 4'b0000, 1'b0);
      step(1'b1, 4'b1111, 1'b0);
    end
    repeat (3) step(1'b1, 4'b1111, 1'b0);
    check_out("sat_full", 1'b1, 4'b0001, 2'd0, 4'b1111, 4'd15);

    // Asynchronous reset in the middle of an offer, between clock edges.
    #1;
    rst_n = 1'b0;
    req_i = 4'b0000;
    #1;
    check_out("async_rst", 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    @(posedge clk);
    #2;
    repeat (6) begin
      step(1'b1, 4'b0000, 1'b1);
      check_out("post_rst", 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    end
    exp_q.push_back(2'd1);
    repeat (3) begin
      step(1'b1, 4'b0010, 1'b1);
      check("relaunch_wait", 32'(valid_o), 32'(1'b0));
    end
    step(1'b1, 4'b0010, 1'b1);
    check_out("relaunch", 1'b1, 4'b0010, 2'd1, 4'b0010, 4'd0);
    step(1'b1, 4'b0010, 1'b1);
    check_out("relaunch_done", 1'b0, 4'b0000, 2'd0, 4'b0000, 4'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
